// File: rtl/glitch_wb_host.sv
// glitch_wb_host: Wishbone initiator for the glitch register slave.
// Splits 32-bit glitch entries into four byte writes (QUEUE_0..QUEUE_3),
// services STATUS reads, and rides out FIFO-full back-pressure on QUEUE_3
// by timing out, polling FIFO_FULL and re-issuing the write.
module glitch_wb_host #(
  parameter logic [3:0]  ADR_STATUS = 4'h0,
  parameter logic [3:0]  ADR_Q0     = 4'h1,
  parameter logic [3:0]  ADR_FULL   = 4'h6,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned MAX_RETRY  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        stat_req,
  output logic        stat_valid,
  output logic        stat_ready,
  output logic        done,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_POLL} state_t;
  typedef enum logic [1:0] {OP_WR, OP_RD_STAT, OP_RD_FULL} op_t;

  state_t        state_q, state_d;
  state_t        after_q, after_d;   // where GAP goes next
  op_t           op_q, op_d;
  logic [1:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;
  logic          pend_q, pend_d;
  logic          cyc_d, stb_d, we_d;
  logic [3:0]    adr_d;
  logic [7:0]    dat_d;
  logic          stat_valid_d, stat_ready_d, done_d, err_d, err_set;

  // Only bit 0 of read data carries information (STATUS ready / FIFO full).
  logic unused_dat;
  assign unused_dat = ^wb_dat_i[7:1];

  // State, bookkeeping and registered outputs; reset releases the bus at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      after_q    <= S_IDLE;
      op_q       <= OP_WR;
      idx_q      <= 2'd0;
      retry_q    <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      pend_q     <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= 4'h0;
      wb_dat_o   <= 8'h00;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      stat_valid <= 1'b0;
      stat_ready <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      after_q    <= after_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
      wb_cyc_o   <= cyc_d;
      wb_stb_o   <= stb_d;
      wb_we_o    <= we_d;
      wb_adr_o   <= adr_d;
      wb_dat_o   <= dat_d;
      cmd_ready  <= (state_d == S_IDLE);
      busy       <= (state_d != S_IDLE);
      stat_valid <= stat_valid_d;
      stat_ready <= stat_ready_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    after_d      = after_q;
    op_d         = op_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    pend_d       = pend_q | stat_req;
    cyc_d        = wb_cyc_o;
    stb_d        = wb_stb_o;
    we_d         = wb_we_o;
    adr_d        = wb_adr_o;
    dat_d        = wb_dat_o;
    stat_valid_d = 1'b0;
    stat_ready_d = stat_ready;
    done_d       = 1'b0;
    err_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          data_d  = cmd_data;
          idx_d   = 2'd0;
          retry_d = '0;
          op_d    = OP_WR;
          cnt_d   = '0;
          state_d = S_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = ADR_Q0;
          dat_d   = cmd_data[7:0];
        end else if (pend_q) begin
          pend_d  = stat_req;
          op_d    = OP_RD_STAT;
          cnt_d   = '0;
          state_d = S_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = ADR_STATUS;
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_GAP;
          after_d = S_IDLE;
          case (op_q)
            OP_WR: begin
              if (idx_q != 2'd3) begin
                idx_d   = idx_q + 2'd1;
                after_d = S_REQ;
              end else begin
                done_d = 1'b1;
              end
            end
            OP_RD_STAT: begin
              stat_ready_d = wb_dat_i[0];
              stat_valid_d = 1'b1;
            end
            default: begin
              // FIFO_FULL poll: empty slot -> re-issue QUEUE_3, else poll again.
              if (!wb_dat_i[0]) begin
                op_d    = OP_WR;
                after_d = S_REQ;
              end else if (retry_q == RW'(MAX_RETRY)) begin
                err_set = 1'b1;
              end else begin
                retry_d = retry_q + RW'(1);
                after_d = S_POLL;
              end
            end
          endcase
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_GAP;
          after_d = S_IDLE;
          // Only QUEUE_3 can stall on a full FIFO; anything else is fatal.
          if (op_q == OP_WR && idx_q == 2'd3 && retry_q != RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            after_d = S_POLL;
          end else begin
            err_set = 1'b1;
          end
        end
      end

      S_GAP: begin
        state_d = after_q;
        if (after_q == S_REQ) begin
          cnt_d = '0;
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = ADR_Q0 + {2'b00, idx_q};
          dat_d = data_q[{idx_q, 3'b000} +: 8];
        end
      end

      S_POLL: begin
        op_d    = OP_RD_FULL;
        cnt_d   = '0;
        state_d = S_REQ;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b0;
        adr_d   = ADR_FULL;
      end

      default: state_d = S_IDLE;
    endcase

    err_d = err_clr ? 1'b0 : (err | err_set);
  end

endmodule

// File: tb/tb_glitch_wb_host.sv
// tb_glitch_wb_host: directed bench with a behavioural glitch slave.
module tb_glitch_wb_host;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_ready;
  logic        stat_req = 1'b0;
  logic        stat_valid, stat_ready, done, busy, err;
  logic        err_clr = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_adr_o;
  logic [7:0]  wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  // Slave controls (driven by the test) and slave/monitor state.
  logic ack_hold = 1'b0;
  logic perm_full = 1'b0;
  logic stat_bit = 1'b0;
  int   full_target = 0;
  int   full_reads = 0;
  logic full_now;
  logic [12:0] log_q[$];
  int   done_cnt = 0, sv_cnt = 0, gap_viol = 0, q3_nak = 0;
  logic prev_acc = 1'b0;

  int checks = 0;
  int errors = 0;

  glitch_wb_host dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .stat_req(stat_req), .stat_valid(stat_valid), .stat_ready(stat_ready),
    .done(done), .busy(busy), .err(err), .err_clr(err_clr),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave: same-cycle ack except QUEUE_3 while full; optional stuck-high ack.
  assign full_now = perm_full || (full_reads < full_target);
  assign wb_ack_i = ack_hold ||
                    (wb_cyc_o && wb_stb_o && !(wb_we_o && wb_adr_o == 4'h4 && full_now));
  assign wb_dat_i = (wb_adr_o == 4'h6) ? {7'b0, full_now} :
                    (wb_adr_o == 4'h0) ? {7'b0, stat_bit} : 8'h00;

  // Bus monitor: logs accepted transfers as {we, adr, data}.
  always @(posedge clk_i) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      log_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : wb_dat_i});
      if (!wb_we_o && wb_adr_o == 4'h6) full_reads <= full_reads + 1;
    end
    if (prev_acc && wb_stb_o) gap_viol <= gap_viol + 1;
    prev_acc <= wb_cyc_o && wb_stb_o && wb_ack_i;
    if (done) done_cnt <= done_cnt + 1;
    if (stat_valid) sv_cnt <= sv_cnt + 1;
    if (wb_cyc_o && wb_stb_o && wb_we_o && wb_adr_o == 4'h4 && !wb_ack_i) q3_nak <= q3_nak + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one entry; lat = edges from acceptance edge to done seen (or -1).
  task automatic run_cmd(input logic [31:0] d, input int budget, output int lat);
    int n;
    lat = -1;
    @(negedge clk_i);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge clk_i); #1;
    cmd_valid = 1'b0;
    n = 1;
    while (n < budget && lat < 0) begin
      if (done) lat = n;
      else begin
        @(posedge clk_i); #1;
        n++;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    while (busy && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
    check({name, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  typedef struct {
    logic [31:0]     data;
    logic            hold;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[4];
  logic [12:0] exp_retry[7];

  initial begin
    int lat, start, d0, g0, s0, n, q0;
    logic seen, rd_bit, done_first;

    vecs[0] = '{data: 32'hDEADBEEF, hold: 1'b0, exp: {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    vecs[1] = '{data: 32'h01234567, hold: 1'b1, exp: {8'h01, 8'h23, 8'h45, 8'h67}};
    vecs[2] = '{data: 32'hFFFF0000, hold: 1'b0, exp: {8'hFF, 8'hFF, 8'h00, 8'h00}};
    vecs[3] = '{data: 32'hA5C33C5A, hold: 1'b1, exp: {8'hA5, 8'hC3, 8'h3C, 8'h5A}};

    exp_retry[0] = {1'b1, 4'h1, 8'h0D};
    exp_retry[1] = {1'b1, 4'h2, 8'hF0};
    exp_retry[2] = {1'b1, 4'h3, 8'hFE};
    exp_retry[3] = {1'b0, 4'h6, 8'h01};
    exp_retry[4] = {1'b0, 4'h6, 8'h01};
    exp_retry[5] = {1'b0, 4'h6, 8'h00};
    exp_retry[6] = {1'b1, 4'h4, 8'hCA};

    // Reset state.
    #1;
    check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_busy_err", {30'b0, busy, err}, 32'd0);
    check("rst_pulses", {30'b0, done, stat_valid}, 32'd0);
    #20;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Table-driven entry writes.
    for (int i = 0; i < 4; i++) begin
      ack_hold = vecs[i].hold;
      start = log_q.size();
      d0 = done_cnt;
      g0 = gap_viol;
      run_cmd(vecs[i].data, 300, lat);
      check("latency", lat, 32'd8);
      wait_idle("vec", 100);
      ack_hold = 1'b0;
      check("n_txn", log_q.size() - start, 32'd4);
      for (int k = 0; k < 4; k++)
        if (start + k < log_q.size())
          check("wr_byte", {19'b0, log_q[start + k]}, {19'b0, 1'b1, 4'(k + 1), vecs[i].exp[k]});
      check("done_once", done_cnt - d0, 32'd1);
      check("stb_gap", gap_viol - g0, 32'd0);
      check("no_err", {31'b0, err}, 32'd0);
    end

    // QUEUE_3 full for two polls, then free.
    start = log_q.size();
    d0 = done_cnt;
    q0 = q3_nak;
    full_target = full_reads + 2;
    run_cmd(32'hCAFEF00D, 300, lat);
    check("retry_latency", lat, 32'd34);
    wait_idle("retry", 100);
    check("retry_q3_nak", q3_nak - q0, 32'd16);
    check("retry_n_txn", log_q.size() - start, 32'd7);
    for (int k = 0; k < 7; k++)
      if (start + k < log_q.size())
        check("retry_txn", {19'b0, log_q[start + k]}, {19'b0, exp_retry[k]});
    check("retry_done", done_cnt - d0, 32'd1);
    check("retry_no_err", {31'b0, err}, 32'd0);

    // FIFO permanently full: abandoned entry, sticky err, err_clr.
    perm_full = 1'b1;
    start = log_q.size();
    d0 = done_cnt;
    run_cmd(32'h55AA1234, 40, lat);
    check("full_no_done_early", lat, 32'hFFFF_FFFF);
    wait_idle("full", 2000);
    perm_full = 1'b0;
    check("full_err", {31'b0, err}, 32'd1);
    check("full_no_done", done_cnt - d0, 32'd0);
    n = 0;
    for (int k = start; k < log_q.size(); k++)
      if (log_q[k][12:8] == 5'h14) n++;
    check("full_no_q3", n, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    check("err_sticky", {31'b0, err}, 32'd1);
    @(negedge clk_i);
    err_clr = 1'b1;
    @(posedge clk_i); #1;
    err_clr = 1'b0;
    check("err_clr", {31'b0, err}, 32'd0);

    // Status read requested mid-entry, for both STATUS bit values.
    for (int b = 1; b >= 0; b--) begin
      stat_bit = b[0];
      start = log_q.size();
      d0 = done_cnt;
      s0 = sv_cnt;
      @(negedge clk_i);
      cmd_valid = 1'b1;
      cmd_data  = 32'h0BADF00D;
      @(negedge clk_i);
      cmd_valid = 1'b0;
      stat_req  = 1'b1;
      @(negedge clk_i);
      stat_req  = 1'b0;
      seen = 1'b0;
      rd_bit = 1'b0;
      done_first = 1'b0;
      n = 0;
      while (!seen && n < 100) begin
        @(posedge clk_i); #1;
        n++;
        if (stat_valid) begin
          seen = 1'b1;
          rd_bit = stat_ready;
          done_first = (done_cnt - d0 == 1);
        end
      end
      check("stat_seen", {31'b0, seen}, 32'd1);
      check("stat_ready", {31'b0, rd_bit}, {31'b0, b[0]});
      check("stat_after_done", {31'b0, done_first}, 32'd1);
      wait_idle("stat", 100);
      check("stat_n_txn", log_q.size() - start, 32'd5);
      if (start + 4 < log_q.size())
        check("stat_txn", {19'b0, log_q[start + 4]}, {19'b0, 1'b0, 4'h0, 7'b0, b[0]});
      check("stat_once", sv_cnt - s0, 32'd1);
    end

    // Asynchronous reset while byte 2 is on the bus.
    d0 = done_cnt;
    @(negedge clk_i);
    cmd_valid = 1'b1;
    cmd_data  = 32'h99887766;
    @(posedge clk_i); #1;
    cmd_valid = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk_i);
      n++;
      if (wb_stb_o && wb_adr_o == 4'h3) seen = 1'b1;
    end
    check("rst_mid_found", {31'b0, seen}, 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    check("rst_mid_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("rst_mid_stb", {31'b0, wb_stb_o}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 32'd0);
    start = log_q.size();
    run_cmd(32'h11223344, 300, lat);
    check("rst_new_latency", lat, 32'd8);
    wait_idle("rst_new", 100);
    if (start < log_q.size())
      check("rst_new_first", {19'b0, log_q[start]}, {19'b0, 1'b1, 4'h1, 8'h44});
    check("rst_new_n_txn", log_q.size() - start, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
